// File: rtl/task_pkg.sv
// Task word layout shared by the task FIFO bank and the RPU task distributor.
package task_pkg;

  localparam int unsigned PtwDef      = 16;
  localparam int unsigned LevelDef    = 4;
  localparam int unsigned TreeNumDef  = 4;
  localparam int unsigned DepthDef    = 8;
  localparam int unsigned TreeBitsDef = $clog2(TreeNumDef);

  localparam int unsigned TaskW     = PtwDef + TreeBitsDef + 1;
  localparam int unsigned IsPushPos = TaskW - 1;
  localparam int unsigned TreeIdLsb = PtwDef;
  localparam int unsigned DataLsb   = 0;

  typedef struct packed {
    logic                   is_push;
    logic [TreeBitsDef-1:0] tree_id;
    logic [PtwDef-1:0]      data;
  } task_t;

endpackage

// File: rtl/task_fifo.sv
// Single circular task buffer with registered read data and registered empty/full flags.
module task_fifo #(
  parameter int unsigned Width = 19,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [PtrW:0]    count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic [Width-1:0] rd_data_q;
  logic             empty_q, full_q;
  logic             do_wr, do_rd;

  // A read on an empty buffer is dropped, so a same-cycle write never bypasses to the output.
  assign do_wr = wr_en_i && !full_q;
  assign do_rd = rd_en_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == (PtrW + 1)'(Depth));
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;
  assign empty_o   = empty_q;
  assign full_o    = full_q;
  assign count_o   = count_q;

endmodule

// File: rtl/task_fifo_bank.sv
// Routes scheduler tasks by treeId to per-RPU task FIFOs through a writable tree-to-level map.
// Optional TASK_FIFO_STATS_EN adds per-FIFO high-water marks and a stall-cycle counter.
module task_fifo_bank
  import task_pkg::*;
#(
  parameter int unsigned PTW      = PtwDef,
  parameter int unsigned LEVEL    = LevelDef,
  parameter int unsigned TREE_NUM = TreeNumDef,
  parameter int unsigned DEPTH    = DepthDef,
  localparam int unsigned LEVEL_BITS    = $clog2(LEVEL),
  localparam int unsigned TREE_NUM_BITS = $clog2(TREE_NUM),
  localparam int unsigned DEPTH_BITS    = $clog2(DEPTH),
  localparam int unsigned TW            = PTW + TREE_NUM_BITS + 1
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_task_valid,
  input  logic                     i_task_is_push,
  input  logic [TREE_NUM_BITS-1:0] i_task_treeId,
  input  logic [PTW-1:0]           i_task_data,
  output logic                     o_task_ready,
  input  logic                     i_cfg_we,
  input  logic [TREE_NUM_BITS-1:0] i_cfg_treeId,
  input  logic [LEVEL_BITS-1:0]    i_cfg_level,
  input  logic [LEVEL-1:0]         i_pop_TaskFIFO,
  output logic [TW-1:0]            o_TaskFIFO_data [LEVEL],
  output logic [LEVEL-1:0]         o_TaskFIFO_empty,
`ifdef TASK_FIFO_STATS_EN
  output logic [DEPTH_BITS:0]      o_hwm [LEVEL],
  output logic [15:0]              o_stall_cnt,
`endif
  output logic [LEVEL-1:0]         o_TaskFIFO_full
);

  logic [LEVEL_BITS-1:0] map_q [TREE_NUM];
  logic [LEVEL_BITS-1:0] target;
  logic [DEPTH_BITS:0]   count [LEVEL];
  logic [TW-1:0]         wr_word;
  logic                  accept;

  assign target       = map_q[i_task_treeId];
  assign o_task_ready = (count[target] != (DEPTH_BITS + 1)'(DEPTH));
  assign accept       = i_task_valid && o_task_ready;
  // Pop tasks carry no payload; zero it so the distributor sees a clean word.
  assign wr_word      = {i_task_is_push, i_task_treeId, i_task_is_push ? i_task_data : '0};

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int t = 0; t < int'(TREE_NUM); t++) begin
        map_q[t] <= LEVEL_BITS'(t % int'(LEVEL));
      end
    end else if (i_cfg_we) begin
      map_q[i_cfg_treeId] <= i_cfg_level;
    end
  end

  for (genvar g = 0; g < int'(LEVEL); g++) begin : g_fifo
    task_fifo #(
      .Width(TW),
      .Depth(DEPTH)
    ) u_task_fifo (
      .clk_i    (i_clk),
      .arst_ni  (i_arst_n),
      .wr_en_i  (accept && (target == LEVEL_BITS'(g))),
      .wr_data_i(wr_word),
      .rd_en_i  (i_pop_TaskFIFO[g]),
      .rd_data_o(o_TaskFIFO_data[g]),
      .empty_o  (o_TaskFIFO_empty[g]),
      .full_o   (o_TaskFIFO_full[g]),
      .count_o  (count[g])
    );
  end

`ifdef TASK_FIFO_STATS_EN
  logic [DEPTH_BITS:0] hwm_q [LEVEL];
  logic [15:0]         stall_q;

  // Count never exceeds DEPTH, so the high-water mark saturates there on its own.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < int'(LEVEL); i++) hwm_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < int'(LEVEL); i++) begin
        if (count[i] > hwm_q[i]) hwm_q[i] <= count[i];
      end
      if (i_task_valid && !o_task_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign o_hwm       = hwm_q;
  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_task_fifo_bank.sv
// Directed self-checking bench for task_fifo_bank (stats checks when TASK_FIFO_STATS_EN is set).
module tb_task_fifo_bank;

  logic        clk;
  logic        rst_n;
  logic        task_valid;
  logic        task_is_push;
  logic [1:0]  task_tree;
  logic [15:0] task_data;
  logic        task_ready;
  logic        cfg_we;
  logic [1:0]  cfg_tree;
  logic [1:0]  cfg_level;
  logic [3:0]  pop;
  logic [18:0] fifo_data [4];
  logic [3:0]  fifo_empty;
  logic [3:0]  fifo_full;
`ifdef TASK_FIFO_STATS_EN
  logic [3:0]  hwm [4];
  logic [15:0] stall_cnt;
`endif

  int n_cmp;
  int n_fail;

  task_fifo_bank u_dut (
    .i_clk           (clk),
    .i_arst_n        (rst_n),
    .i_task_valid    (task_valid),
    .i_task_is_push  (task_is_push),
    .i_task_treeId   (task_tree),
    .i_task_data     (task_data),
    .o_task_ready    (task_ready),
    .i_cfg_we        (cfg_we),
    .i_cfg_treeId    (cfg_tree),
    .i_cfg_level     (cfg_level),
    .i_pop_TaskFIFO  (pop),
    .o_TaskFIFO_data (fifo_data),
    .o_TaskFIFO_empty(fifo_empty),
`ifdef TASK_FIFO_STATS_EN
    .o_hwm           (hwm),
    .o_stall_cnt     (stall_cnt),
`endif
    .o_TaskFIFO_full (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] tree, input logic [15:0] data, input logic is_push);
    task_valid   = 1'b1;
    task_is_push = is_push;
    task_tree    = tree;
    task_data    = data;
    tick();
    task_valid = 1'b0;
  endtask

  task automatic do_pop(input logic [3:0] mask);
    pop = mask;
    tick();
    pop = 4'b0;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++; if (fifo_empty !== 4'hF) begin n_fail++;
      $display("FAIL reset_empty: got %h want %h", fifo_empty, 4'hF); end
    n_cmp++; if (fifo_full !== 4'h0) begin n_fail++;
      $display("FAIL reset_full: got %h want %h", fifo_full, 4'h0); end
    n_cmp++; if (fifo_data[0] !== 19'h0) begin n_fail++;
      $display("FAIL reset_data0: got %h want %h", fifo_data[0], 19'h0); end
    n_cmp++; if (fifo_data[3] !== 19'h0) begin n_fail++;
      $display("FAIL reset_data3: got %h want %h", fifo_data[3], 19'h0); end
    n_cmp++; if (task_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got %h want %h", task_ready, 1'b1); end
  endtask

  task automatic test_basic();
    push(2'd2, 16'h1234, 1'b1);
    n_cmp++; if (fifo_empty !== 4'b1011) begin n_fail++;
      $display("FAIL basic_empty_after_push: got %h want %h", fifo_empty, 4'b1011); end
    do_pop(4'b0100);
    n_cmp++; if (fifo_data[2] !== 19'h61234) begin n_fail++;
      $display("FAIL basic_pop_data: got %h want %h", fifo_data[2], 19'h61234); end
    n_cmp++; if (fifo_empty !== 4'hF) begin n_fail++;
      $display("FAIL basic_empty_after_pop: got %h want %h", fifo_empty, 4'hF); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) push(2'd0, 16'h0100 + 16'(i), 1'b1);
    n_cmp++; if (fifo_full !== 4'b0001) begin n_fail++;
      $display("FAIL full_flag: got %h want %h", fifo_full, 4'b0001); end
    task_valid = 1'b1; task_is_push = 1'b1; task_tree = 2'd0; task_data = 16'hDEAD;
    #1;
    n_cmp++; if (task_ready !== 1'b0) begin n_fail++;
      $display("FAIL full_ready_tree0: got %h want %h", task_ready, 1'b0); end
    task_tree = 2'd1; task_data = 16'h0777;
    #1;
    n_cmp++; if (task_ready !== 1'b1) begin n_fail++;
      $display("FAIL full_ready_tree1: got %h want %h", task_ready, 1'b1); end
    tick();
    task_valid = 1'b0;
    n_cmp++; if (fifo_empty !== 4'b1100) begin n_fail++;
      $display("FAIL full_empty_mix: got %h want %h", fifo_empty, 4'b1100); end
    do_pop(4'b0001);
    n_cmp++; if (fifo_data[0] !== 19'h40100) begin n_fail++;
      $display("FAIL full_first_pop: got %h want %h", fifo_data[0], 19'h40100); end
    task_valid = 1'b1; task_tree = 2'd0;
    #1;
    n_cmp++; if (task_ready !== 1'b1) begin n_fail++;
      $display("FAIL full_ready_after_pop: got %h want %h", task_ready, 1'b1); end
    task_valid = 1'b0;
    n_cmp++; if (fifo_full !== 4'b0000) begin n_fail++;
      $display("FAIL full_flag_after_pop: got %h want %h", fifo_full, 4'b0000); end
    for (int i = 0; i < 7; i++) do_pop(4'b0001);
    n_cmp++; if (fifo_data[0] !== 19'h40107) begin n_fail++;
      $display("FAIL full_last_pop: got %h want %h", fifo_data[0], 19'h40107); end
    do_pop(4'b0010);
    n_cmp++; if (fifo_data[1] !== 19'h50777) begin n_fail++;
      $display("FAIL full_tree1_pop: got %h want %h", fifo_data[1], 19'h50777); end
    n_cmp++; if (fifo_empty !== 4'hF) begin n_fail++;
      $display("FAIL full_drained: got %h want %h", fifo_empty, 4'hF); end
  endtask

  task automatic test_pop_empty();
    push(2'd3, 16'hBEEF, 1'b1);
    do_pop(4'b1000);
    n_cmp++; if (fifo_data[3] !== 19'h7BEEF) begin n_fail++;
      $display("FAIL pe_first: got %h want %h", fifo_data[3], 19'h7BEEF); end
    do_pop(4'b1000);
    n_cmp++; if (fifo_data[3] !== 19'h7BEEF) begin n_fail++;
      $display("FAIL pe_hold: got %h want %h", fifo_data[3], 19'h7BEEF); end
    n_cmp++; if (fifo_empty !== 4'hF) begin n_fail++;
      $display("FAIL pe_empty: got %h want %h", fifo_empty, 4'hF); end
    push(2'd3, 16'h0042, 1'b1);
    do_pop(4'b1000);
    n_cmp++; if (fifo_data[3] !== 19'h70042) begin n_fail++;
      $display("FAIL pe_after: got %h want %h", fifo_data[3], 19'h70042); end
  endtask

  task automatic test_simultaneous();
    push(2'd1, 16'h00A1, 1'b1);
    push(2'd1, 16'h00A2, 1'b1);
    push(2'd1, 16'hFFFF, 1'b0);
    task_valid = 1'b1; task_is_push = 1'b1; task_tree = 2'd1; task_data = 16'h00A4;
    pop = 4'b0010;
    tick();
    task_valid = 1'b0; pop = 4'b0;
    n_cmp++; if (fifo_data[1] !== 19'h500A1) begin n_fail++;
      $display("FAIL sim_oldest: got %h want %h", fifo_data[1], 19'h500A1); end
    do_pop(4'b0010);
    n_cmp++; if (fifo_data[1] !== 19'h500A2) begin n_fail++;
      $display("FAIL sim_second: got %h want %h", fifo_data[1], 19'h500A2); end
    do_pop(4'b0010);
    n_cmp++; if (fifo_data[1] !== 19'h10000) begin n_fail++;
      $display("FAIL sim_pop_task_word: got %h want %h", fifo_data[1], 19'h10000); end
    n_cmp++; if (fifo_empty[1] !== 1'b0) begin n_fail++;
      $display("FAIL sim_one_left: got %h want %h", fifo_empty[1], 1'b0); end
    do_pop(4'b0010);
    n_cmp++; if (fifo_data[1] !== 19'h500A4) begin n_fail++;
      $display("FAIL sim_fourth: got %h want %h", fifo_data[1], 19'h500A4); end
    n_cmp++; if (fifo_empty[1] !== 1'b1) begin n_fail++;
      $display("FAIL sim_count3_drained: got %h want %h", fifo_empty[1], 1'b1); end
    task_valid = 1'b1; task_tree = 2'd1; task_data = 16'h00B5;
    pop = 4'b0010;
    tick();
    task_valid = 1'b0; pop = 4'b0;
    n_cmp++; if (fifo_data[1] !== 19'h500A4) begin n_fail++;
      $display("FAIL sim_empty_no_bypass: got %h want %h", fifo_data[1], 19'h500A4); end
    n_cmp++; if (fifo_empty[1] !== 1'b0) begin n_fail++;
      $display("FAIL sim_empty_count1: got %h want %h", fifo_empty[1], 1'b0); end
    do_pop(4'b0010);
    n_cmp++; if (fifo_data[1] !== 19'h500B5) begin n_fail++;
      $display("FAIL sim_empty_written: got %h want %h", fifo_data[1], 19'h500B5); end
    n_cmp++; if (fifo_empty[1] !== 1'b1) begin n_fail++;
      $display("FAIL sim_empty_final: got %h want %h", fifo_empty[1], 1'b1); end
  endtask

  task automatic test_cfg();
    cfg_we = 1'b1; cfg_tree = 2'd3; cfg_level = 2'd0;
    push(2'd3, 16'h00C3, 1'b1);
    cfg_we = 1'b0;
    push(2'd3, 16'h00C4, 1'b1);
    n_cmp++; if (fifo_empty !== 4'b0110) begin n_fail++;
      $display("FAIL cfg_empty: got %h want %h", fifo_empty, 4'b0110); end
    do_pop(4'b1001);
    n_cmp++; if (fifo_data[3] !== 19'h700C3) begin n_fail++;
      $display("FAIL cfg_old_map: got %h want %h", fifo_data[3], 19'h700C3); end
    n_cmp++; if (fifo_data[0] !== 19'h700C4) begin n_fail++;
      $display("FAIL cfg_new_map: got %h want %h", fifo_data[0], 19'h700C4); end
  endtask

  task automatic test_reset_midop();
    push(2'd2, 16'h5555, 1'b1);
    push(2'd0, 16'h6666, 1'b1);
    do_pop(4'b0100);
    n_cmp++; if (fifo_data[2] !== 19'h65555) begin n_fail++;
      $display("FAIL mid_pre: got %h want %h", fifo_data[2], 19'h65555); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (fifo_empty !== 4'hF) begin n_fail++;
      $display("FAIL mid_empty: got %h want %h", fifo_empty, 4'hF); end
    n_cmp++; if (fifo_data[2] !== 19'h0) begin n_fail++;
      $display("FAIL mid_data: got %h want %h", fifo_data[2], 19'h0); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    push(2'd3, 16'h3333, 1'b1);
    n_cmp++; if (fifo_empty !== 4'b0111) begin n_fail++;
      $display("FAIL mid_map_default: got %h want %h", fifo_empty, 4'b0111); end
    do_pop(4'b1000);
    n_cmp++; if (fifo_data[3] !== 19'h73333) begin n_fail++;
      $display("FAIL mid_after: got %h want %h", fifo_data[3], 19'h73333); end
  endtask

`ifdef TASK_FIFO_STATS_EN
  task automatic test_stats();
    pulse_reset();
    for (int i = 0; i < 8; i++) push(2'd0, 16'h0200 + 16'(i), 1'b1);
    task_valid = 1'b1; task_is_push = 1'b1; task_tree = 2'd0;
    repeat (5) tick();
    task_valid = 1'b0;
    n_cmp++; if (stall_cnt !== 16'd5) begin n_fail++;
      $display("FAIL stats_stall: got %0d want %0d", stall_cnt, 5); end
    n_cmp++; if (hwm[0] !== 4'd8) begin n_fail++;
      $display("FAIL stats_hwm0: got %0d want %0d", hwm[0], 8); end
    task_valid = 1'b1; task_tree = 2'd1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++;
      $display("FAIL stats_rst_stall: got %0d want %0d", stall_cnt, 0); end
    n_cmp++; if (hwm[0] !== 4'd0) begin n_fail++;
      $display("FAIL stats_rst_hwm: got %0d want %0d", hwm[0], 0); end
    n_cmp++; if (fifo_empty !== 4'hF || fifo_full !== 4'h0) begin n_fail++;
      $display("FAIL stats_rst_flags: got %h/%h want f/0", fifo_empty, fifo_full); end
    task_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    task_valid = 1'b0; task_is_push = 1'b0; task_tree = '0; task_data = '0;
    cfg_we = 1'b0; cfg_tree = '0; cfg_level = '0; pop = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_full();
    test_pop_empty();
    test_simultaneous();
    test_cfg();
    test_reset_midop();
`ifdef TASK_FIFO_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
